fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter XLEN, default 32: address/data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pc_src  input  1  redirect from control unit (taken branch/jump), qualified by instr_valid & ~stall.
REQ-006 pc_sel  input  1  target source: 0 = pc + imm_ext, 1 = alu_result with bit0 cleared (jalr).
REQ-007 imm_ext  input  32  sign-extended immediate of current instruction.
REQ-008 alu_result  input  32  ALU output for jalr target.
REQ-009 stall  input  1  downstream hold; current instruction not consumed this cycle.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  word-aligned fetch address.
REQ-012 imem_gnt  input  1  request accepted this cycle.
REQ-013 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-014 imem_rdata  input  32  fetched instruction word.
REQ-015 instr  output  32  registered instruction to decode/control.
REQ-016 instr_valid  output  1  instr, pc, pc_plus4 valid.
REQ-017 pc  output  32  address of instr.
REQ-018 pc_plus4  output  32  pc + 4, combinational from pc (jal/jalr link value).
REQ-019 fetch_fault  output  1  sticky misaligned-target flag.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, VALID, FAULT.
REQ-021 IDLE: outputs quiet; unconditionally to REQ next cycle.
REQ-022 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT, else stay REQ with address stable.
REQ-023 WAIT: imem_req=0; imem_rvalid=1 -> capture imem_rdata into instr, go VALID; otherwise stay.
REQ-024 VALID: instr_valid=1; stall=1 -> hold instr and pc unchanged; stall=0 -> consume, update pc, go REQ.
REQ-025 Next pc on consume: pc_src=0 -> pc+4; pc_src=1 & pc_sel=0 -> pc+imm_ext; pc_src=1 & pc_sel=1 -> {alu_result[31:1],1'b0}.
REQ-026 All pc arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
REQ-027 Redirect target with bits[1:0]!=0 on consume -> pc not updated, fetch_fault=1, go FAULT.
REQ-028 FAULT: terminal until reset; imem_req=0, instr_valid=0.
REQ-029 pc_src/pc_sel/imm_ext/alu_result ignored outside VALID&~stall.
REQ-030 imem_rvalid in REQ/IDLE ignored; imem_gnt outside REQ ignored.
REQ-031 Throughput: minimum 3 cycles per instruction (REQ, WAIT, VALID) with gnt and rvalid immediate.
REQ-032 imem_gnt and imem_rvalid in the same REQ cycle: gnt honoured, rvalid dropped.

Reset
REQ-033 rst=0 asynchronously: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_fault=0.
REQ-034 Reset mid-WAIT discards the outstanding response; first post-reset request uses RESET_PC.

Structure
REQ-035 Shared package holds the FSM state encoding and the NOP constant 32'h0000_0013.
REQ-036 One sub-module, next_pc_gen: combinational next-pc mux and misalignment check.

Verification
REQ-037 Reset release, gnt/rvalid immediate, rdata=32'h00500093 -> imem_addr 0 in REQ, instr_valid in 3rd cycle, pc=0, pc_plus4=4.
REQ-038 VALID at pc=32'h10, pc_src=1, pc_sel=0, imm_ext=32'hFFFF_FFF8 -> next imem_addr=32'h08.
REQ-039 VALID at pc=32'h20, pc_src=1, pc_sel=1, alu_result=32'h101 -> next imem_addr=32'h100.
REQ-040 stall=1 for 4 cycles in VALID -> instr, pc constant, imem_req=0; release -> pc+4 fetched.
REQ-041 pc_src=1, pc_sel=0, imm_ext=32'h2 -> fetch_fault=1, FAULT, no further imem_req until reset.
REQ-042 gnt delayed 3 cycles, rst asserted in WAIT -> immediate reset values; next request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared types: FSM state encoding,
// the reset instruction and an alignment helper.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_FAULT
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
// master: fetch side (req/addr out); slave: memory side.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_next_pc_gen.sv
// Next-pc mux: sequential, branch (pc+imm) or jalr target,
// plus a misalignment flag for redirect targets.
module next_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pc_src_i,
  input  logic        pc_sel_i,
  input  logic [31:0] imm_ext_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] target;

  always_comb begin
    pc_plus4_o = pc_i + 32'd4;
    if (pc_sel_i) begin
      target = {alu_result_i[31:1], 1'b0};
    end else begin
      target = pc_i + imm_ext_i;
    end
    next_pc_o    = pc_src_i ? target : pc_plus4_o;
    // pc+4 from an aligned pc is always aligned;
    // only a redirect can fault.
    misaligned_o = pc_src_i & misaligned(target);
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: REQ/WAIT/VALID fetch loop over the imem bus,
// redirect handling and sticky fault on misaligned targets.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            stall,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         fault_q, fault_d;

  logic [31:0]  next_pc;
  logic         misal;

  next_pc_gen u_npc (
    .pc_i         (pc_q),
    .pc_src_i     (pc_src),
    .pc_sel_i     (pc_sel),
    .imm_ext_i    (imm_ext),
    .alu_result_i (alu_result),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc),
    .misaligned_o (misal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      // rvalid here is a stray beat; only gnt counts
      S_REQ: begin
        if (imem.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          if (misal) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == S_VALID);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch,
// redirects, stall, wrap, reset in WAIT and fault.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src, pc_sel, stall;
  logic [31:0] imm_ext, alu_result;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src      (pc_src),
    .pc_sel      (pc_sel),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .stall       (stall),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_fault (fetch_fault)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output int k);
    k = 0;
    while (imem.imem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_seen", {31'd0, imem.imem_req}, 32'd1);
  endtask

  task automatic fetch(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  int          gdly,
    input  bit          dual,
    output int          k
  );
    wait_req(k);
    check("addr", imem.imem_addr, addr);
    check("ivalid_req", {31'd0, instr_valid}, 32'd0);
    repeat (gdly) begin
      imem.imem_gnt = 1'b0;
      @(negedge clk);
      check("req_hold", {31'd0, imem.imem_req}, 32'd1);
      check("addr_hold", imem.imem_addr, addr);
    end
    imem.imem_gnt = 1'b1;
    if (dual) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    imem.imem_gnt    = 1'b0;
    check("req_wait", {31'd0, imem.imem_req}, 32'd0);
    check("ivalid_wait", {31'd0, instr_valid}, 32'd0);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = data;
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
    check("ivalid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("pc", pc, addr);
    check("pc_plus4", pc_plus4, addr + 32'd4);
  endtask

  task automatic consume(
    input logic        src,
    input logic        sel,
    input logic [31:0] imm,
    input logic [31:0] alu
  );
    pc_src     = src;
    pc_sel     = sel;
    imm_ext    = imm;
    alu_result = alu;
    stall      = 1'b0;
    @(negedge clk);
    stall      = 1'b1;
    pc_src     = 1'b0;
    pc_sel     = 1'b0;
    imm_ext    = 32'h0;
    alu_result = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] a;
    rst = 1'b0;
    pc_src = 1'b0; pc_sel = 1'b0; stall = 1'b1;
    imm_ext = 32'h0; alu_result = 32'h0;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("rst_addr", imem.imem_addr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b1;

    fetch(32'h0, 32'h0050_0093, 0, 1'b0, k);
    check("idle_cycles", k, 32'd1);

    for (int i = 0; i < 4; i++) begin
      consume(1'b0, 1'b0, 32'h0, 32'h0);
      a = 32'(4 * (i + 1));
      fetch(a, 32'h1000_0000 | a, i, i == 1, k);
    end

    consume(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h55);
    fetch(32'h08, 32'h2000_0008, 0, 1'b0, k);
    consume(1'b1, 1'b0, 32'h18, 32'h0);
    fetch(32'h20, 32'h2000_0020, 2, 1'b0, k);
    consume(1'b1, 1'b1, 32'hAAAA_AAA8, 32'h101);
    fetch(32'h100, 32'h2000_0100, 0, 1'b0, k);

    repeat (4) begin
      pc_src = 1'b1; pc_sel = 1'b1; alu_result = 32'h200;
      @(negedge clk);
      check("stall_instr", instr, 32'h2000_0100);
      check("stall_pc", pc, 32'h100);
      check("stall_req", {31'd0, imem.imem_req}, 32'd0);
      check("stall_ivalid", {31'd0, instr_valid}, 32'd1);
    end
    consume(1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h104, 32'h2000_0104, 0, 1'b0, k);

    consume(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFD);
    fetch(32'hFFFF_FFFC, 32'h3000_0000, 0, 1'b0, k);
    consume(1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h0, 32'h3000_0004, 0, 1'b0, k);

    consume(1'b0, 1'b0, 32'h0, 32'h0);
    wait_req(k);
    check("rw_addr", imem.imem_addr, 32'h4);
    repeat (3) @(negedge clk);
    imem.imem_gnt = 1'b1;
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    check("rw_inwait", {31'd0, imem.imem_req}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rw_pc", pc, 32'h0);
    check("rw_addr0", imem.imem_addr, 32'h0);
    check("rw_req", {31'd0, imem.imem_req}, 32'd0);
    check("rw_instr", instr, 32'h0000_0013);
    check("rw_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rw_fault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hBAAD_F00D;
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
    rst = 1'b1;
    fetch(32'h0, 32'h4000_0000, 0, 1'b0, k);
    check("rw_idle", k, 32'd1);

    consume(1'b1, 1'b0, 32'h2, 32'h0);
    check("flt_fault", {31'd0, fetch_fault}, 32'd1);
    check("flt_pc", pc, 32'h0);
    check("flt_req", {31'd0, imem.imem_req}, 32'd0);
    check("flt_ivalid", {31'd0, instr_valid}, 32'd0);
    repeat (5) begin
      imem.imem_gnt    = 1'b1;
      imem.imem_rvalid = 1'b1;
      stall            = 1'b0;
      @(negedge clk);
      check("flt_req_h", {31'd0, imem.imem_req}, 32'd0);
      check("flt_fault_h", {31'd0, fetch_fault}, 32'd1);
      check("flt_ivalid_h", {31'd0, instr_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
